// File: rtl/display_bcd_scheduler.sv
// Two-channel arbiter feeding a 3-digit BCD display through a sequential double-dabble converter.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_bcd_scheduler #(
  parameter logic [23:0] HOLD_CYCLES = 24'd12_000_000,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [9:0] value0,
  input  logic [9:0] value1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [1:0] dbg_state
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Handshake: req[n] is a level; a request is taken on the rising edge where
  // it is seen in IDLE (or HOLD for channel 1), and gnt[n] is high for exactly
  // the following cycle. done pulses for the cycle after the digits change.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        accept0;
  logic        accept1;
  logic [9:0]  cap_raw;
  logic        cap_ovf;
  logic [9:0]  cap_val;
  logic [21:0] sr;
  logic [3:0]  iter;
  logic        ch;
  logic        ovf_pend;
  logic [23:0] hold_cnt;
  logic [3:0]  raw_h;
  logic [3:0]  raw_t;
  logic [3:0]  raw_u;
  logic [3:0]  disp_h;
  logic [3:0]  disp_t;

  function automatic logic [21:0] dabble_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[10 + 4*i +: 4] >= 4'd5) t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  always_comb begin
    next_state = state;
    accept0    = 1'b0;
    accept1    = 1'b0;
    case (state)
      IDLE: begin
        if (req[1]) begin
          accept1    = 1'b1;
          next_state = CONVERT;
        end else if (req[0]) begin
          accept0    = 1'b1;
          next_state = CONVERT;
        end
      end
      CONVERT: if (iter == 4'd9) next_state = COMMIT;
      COMMIT: next_state = (ch && (HOLD_CYCLES != 24'd0)) ? HOLD : IDLE;
      HOLD: begin
        // Channel 0 stays pending here; only an alert may preempt the hold.
        if (req[1]) begin
          accept1    = 1'b1;
          next_state = CONVERT;
        end else if (hold_cnt == 24'd0) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cap_raw = accept1 ? value1 : value0;
    cap_ovf = (cap_raw > 10'd999);
    cap_val = cap_ovf ? 10'd999 : cap_raw;
  end

  assign raw_h  = sr[21:18];
  assign raw_t  = sr[17:14];
  assign raw_u  = sr[13:10];
  assign disp_h = (BLANK_EN && raw_h == 4'd0) ? BLANK_CODE : raw_h;
  assign disp_t = (BLANK_EN && raw_h == 4'd0 && raw_t == 4'd0) ? BLANK_CODE : raw_t;

  assign busy      = (state == CONVERT) || (state == COMMIT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      iter     <= '0;
      ch       <= 1'b0;
      ovf_pend <= 1'b0;
      gnt      <= 2'b00;
      done     <= 1'b0;
      ovf      <= 1'b0;
      units    <= 4'd0;
      tens     <= 4'd0;
      hundreds <= 4'd0;
    end else begin
      gnt  <= {accept1, accept0};
      done <= (state == COMMIT);
      if (accept0 || accept1) begin
        sr       <= {12'd0, cap_val};
        iter     <= 4'd0;
        ch       <= accept1;
        ovf_pend <= cap_ovf;
      end else if (state == CONVERT) begin
        sr   <= dabble_step(sr);
        iter <= iter + 4'd1;
      end
      // All three digits and OVF change on one edge so the display never tears.
      if (state == COMMIT) begin
        hundreds <= disp_h;
        tens     <= disp_t;
        units    <= raw_u;
        ovf      <= ovf_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 24'd0;
    end else if (state == COMMIT && next_state == HOLD) begin
      hold_cnt <= HOLD_CYCLES - 24'd1;
    end else if (state == HOLD && hold_cnt != 24'd0) begin
      hold_cnt <= hold_cnt - 24'd1;
    end
  end

endmodule

// File: tb/tb_display_bcd_scheduler.sv
// Directed bench for display_bcd_scheduler with a queue of expected {ovf,hundreds,tens,units}.
// Build with LEADING_ZERO_BLANK_EN defined to cover the blanking variant.
module tb_display_bcd_scheduler;
  localparam logic [23:0] HOLD = 24'd20;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [9:0] value0;
  logic [9:0] value1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [1:0] dbg_state;

  logic [12:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  display_bcd_scheduler #(.HOLD_CYCLES(HOLD), .BLANK_CODE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .value0(value0), .value1(value1),
    .gnt(gnt), .busy(busy), .done(done), .ovf(ovf), .units(units),
    .tens(tens), .hundreds(hundreds), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, independent of the shift-add engine.
  function automatic logic [12:0] model(input logic [9:0] v);
    logic       o;
    int         c;
    logic [3:0] h, t, u;
    o = (v > 10'd999);
    c = o ? 999 : int'(v);
    h = 4'(c / 100);
    t = 4'((c / 10) % 10);
    u = 4'(c % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 4'd0) begin
      if (t == 4'd0) t = 4'hF;
      h = 4'hF;
    end
`endif
    return {o, h, t, u};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for DONE (n=1 is the negedge where GNT was seen), checks latency, pops and compares.
  task automatic wait_done(input string tag);
    int n;
    logic [12:0] e;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 12);
    check({tag, "_busy_off"}, busy, 1'b0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1fff;
    check({tag, "_digits"}, {ovf, hundreds, tens, units}, e);
  endtask

  // Drives a channel-0 request, checks the grant pulse, then waits for the commit.
  task automatic ch0_request(input logic [9:0] v, input string tag);
    value0 = v;
    req    = 2'b01;
    exp_q.push_back(model(v));
    @(negedge clk);
    check({tag, "_gnt"}, gnt, 2'b01);
    check({tag, "_busy_on"}, busy, 1'b1);
    req = 2'b00;
    wait_done(tag);
  endtask

  task automatic count_to_gnt0(input string tag);
    int m;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!gnt[0] && m < 80);
    // DONE is the first HOLD cycle; grant lands one edge after HOLD ends.
    check(tag, m, 32'(HOLD) + 1);
  endtask

  initial begin
    logic seen;
    rst_n  = 1'b0;
    req    = 2'b00;
    value0 = '0;
    value1 = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {gnt, busy, done, ovf, hundreds, tens, units, dbg_state}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    ch0_request(10'd345, "v345");

    // Both channels at once: alert wins, channel 0 waits out the hold.
    value1 = 10'd7;
    value0 = 10'd500;
    req    = 2'b11;
    exp_q.push_back(model(10'd7));
    exp_q.push_back(model(10'd500));
    @(negedge clk);
    check("both_gnt", gnt, 2'b10);
    req = 2'b01;
    wait_done("v7");
    check("hold_state", dbg_state, 2'd3);
    count_to_gnt0("hold_len");
    req = 2'b00;
    wait_done("v500");

    ch0_request(10'd1023, "v1023");
    ch0_request(10'd999, "v999");

    // Alert during hold: channel 0 ignored, channel 1 preempts and restarts the hold.
    value1 = 10'd100;
    req    = 2'b10;
    exp_q.push_back(model(10'd100));
    @(negedge clk);
    check("v100_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_done("v100");
    value0 = 10'd77;
    req    = 2'b01;
    seen   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= (gnt != 2'b00);
    end
    check("hold_ignores_ch0", seen, 1'b0);
    value1 = 10'd42;
    req    = 2'b11;
    exp_q.push_back(model(10'd42));
    exp_q.push_back(model(10'd77));
    @(negedge clk);
    check("hold_ch1_gnt", gnt, 2'b10);
    req = 2'b01;
    wait_done("v42");
    count_to_gnt0("hold_restart");
    req = 2'b00;
    wait_done("v77");

    // Reset during the fifth conversion cycle.
    value0 = 10'd888;
    req    = 2'b01;
    @(negedge clk);
    check("abort_gnt", gnt, 2'b01);
    req = 2'b00;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {gnt, busy, done, ovf, hundreds, tens, units, dbg_state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_digits", {ovf, hundreds, tens, units}, 0);

    ch0_request(10'd5, "v5");
    ch0_request(10'd0, "v0");
    ch0_request(10'd60, "v60");
    for (int i = 0; i < 4; i++) begin
      ch0_request(10'($urandom_range(0, 1023)), "rand");
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
